// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM encoding and default widths.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_ADDR_W   = 32;
  localparam int unsigned FETCH_DATA_W   = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'd0;

  function automatic logic is_fault(input fetch_state_e st);
    return st == ST_FAULT;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instruction} pairs between the fetch stage and decode.
// Flush empties it in one cycle; the head reads as zero while empty.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned PC_W   = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [PC_W-1:0]                i_push_pc,
  input  logic [DATA_W-1:0]              i_push_instr,
  input  logic                           i_pop,
  input  logic                           i_flush,
  output logic                           o_valid,
  output logic [PC_W-1:0]                o_pc,
  output logic [DATA_W-1:0]              o_instr,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]   r_pc_mem    [DEPTH];
  logic [DATA_W-1:0] r_instr_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [CNT_W-1:0]  r_count;
  logic              w_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_valid = (r_count != '0);
  assign o_valid = w_valid;
  assign o_count = r_count;
  assign o_pc    = w_valid ? r_pc_mem[r_rd]    : '0;
  assign o_instr = w_valid ? r_instr_mem[r_rd] : '0;

  // Pointers and occupancy; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= ptr_inc(r_wr);
      if (i_pop)  r_rd <= ptr_inc(r_rd);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_pc_mem[r_wr]    <= i_push_pc;
      r_instr_mem[r_wr] <= i_push_instr;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a synchronous instruction memory and feeds decode.
// Define FETCH_BOUNDS_CHK_EN to trap on PCs at or beyond MEM_DEPTH (sticky FAULT state).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned       DATA_W    = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(FETCH_RESET_PC),
  parameter int unsigned       BUF_DEPTH = 2,
  parameter int unsigned       MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] instruction_address,
  input  logic [DATA_W-1:0] instruction_out,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  if (BUF_DEPTH < 2 || MEM_DEPTH < 1) begin : g_param_chk
    $error("instruction_fetch: BUF_DEPTH must be >= 2 and MEM_DEPTH >= 1");
  end

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ;
  logic              w_pop;
  logic              w_redirect;
  logic              w_room;
  logic              w_want;
  logic              w_issue;
  logic              w_capture;
  logic              w_fault_set;

  assign w_pop      = instr_valid & instr_ready;
  assign w_redirect = redirect_valid & ~is_fault(r_state);

  // Slots already promised: buffered entries plus the outstanding read, less this cycle's pop.
  assign w_occ  = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
  assign w_room = (w_occ < (CNT_W + 1)'(BUF_DEPTH));

  // IDLE with fetch_en already issues, so the first fetch leaves in the cycle fetch_en rises.
  assign w_want = fetch_en & ~is_fault(r_state) & w_room & ~w_redirect;

`ifdef FETCH_BOUNDS_CHK_EN
  logic w_oob;
  logic r_fault;

  assign w_oob       = (r_pc >= ADDR_W'(MEM_DEPTH));
  assign w_issue     = w_want & ~w_oob;
  assign w_fault_set = w_want & w_oob;
  assign fetch_fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fault <= 1'b0;
    else if (w_fault_set) r_fault <= 1'b1;
  end
`else
  assign w_issue     = w_want;
  assign w_fault_set = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // A response arriving in the redirect cycle belongs to the abandoned path.
  assign w_capture = r_inflight & ~w_redirect;

  // Issue stage: PC, outstanding-read flag and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_redirect)   r_pc <= redirect_pc;
      else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
      if (w_fault_set) begin
        r_state <= ST_FAULT;
      end else begin
        case (r_state)
          ST_IDLE: if (fetch_en)  r_state <= ST_RUN;
          ST_RUN:  if (!fetch_en) r_state <= ST_IDLE;
          default: r_state <= r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_inflight_pc <= r_pc;
  end

  assign instruction_address = r_pc;

  // Capture stage: memory data joins its PC in the buffer.
  fetch_buffer #(
    .DEPTH  (BUF_DEPTH),
    .PC_W   (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_capture),
    .i_push_pc    (r_inflight_pc),
    .i_push_instr (instruction_out),
    .i_pop        (w_pop & ~w_redirect),
    .i_flush      (w_redirect),
    .o_valid      (instr_valid),
    .o_pc         (instr_pc),
    .o_instr      (instr),
    .o_count      (w_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a queue-based reference of the fetch rules.
module tb_instruction_fetch;

  localparam int BD = 2;
  localparam int MD = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        instr_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction_out = '0;
  logic [31:0] instruction_address;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] q[$];
  logic [31:0] acc[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_ifpc = '0;
  logic        m_inflight = 1'b0;
  logic        m_fault = 1'b0;
  bit          live = 1'b0;

  instruction_fetch #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .RESET_PC  (32'd0),
    .BUF_DEPTH (BD),
    .MEM_DEPTH (MD)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_en            (fetch_en),
    .instruction_address (instruction_address),
    .instruction_out     (instruction_out),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr               (instr),
    .instr_pc            (instr_pc),
    .fetch_fault         (fetch_fault)
  );

  initial forever #5 clk = ~clk;

  // Synchronous memory: word n holds n + 100.
  initial forever begin
    @(posedge clk);
    instruction_out <= instruction_address + 32'd100;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Reference: buffer as a queue of PCs, one outstanding read, PC counter, sticky fault.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_pc = '0;
      m_inflight = 1'b0;
      m_fault = 1'b0;
      live = 1'b1;
    end else begin
      bit pop, redir, want, oob;
      int occ;
      pop   = (q.size() != 0) && instr_ready;
      redir = redirect_valid && !m_fault;
      occ   = q.size() + int'(m_inflight) - int'(pop);
      want  = fetch_en && !m_fault && !redir && (occ < BD);
`ifdef FETCH_BOUNDS_CHK_EN
      oob = (m_pc >= MD);
`else
      oob = 1'b0;
`endif
      if (redir) begin
        q.delete();
        m_inflight = 1'b0;
        m_pc = redirect_pc;
      end else begin
        if (pop) void'(q.pop_front());
        if (m_inflight) q.push_back(m_ifpc);
        m_inflight = want && !oob;
        if (want && !oob) begin
          m_ifpc = m_pc;
          m_pc = m_pc + 32'd1;
        end
        if (want && oob) m_fault = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("cmp_valid", 32'(instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("cmp_pc", instr_pc, q[0]);
        chk("cmp_instr", instr, q[0] + 32'd100);
      end
      chk("cmp_addr", instruction_address, m_pc);
      chk("cmp_fault", 32'(fetch_fault), 32'(m_fault));
    end
  end

  // Log of every PC decode actually accepted.
  initial forever begin
    @(posedge clk);
    if (rst_n && instr_valid && instr_ready) acc.push_back(instr_pc);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_acc[19];
    exp_acc = '{0, 1, 2, 3, 4, 5, 20, 21, 22, 8, 9, 10, 11, 12, 13, 60, 61, 62, 63};

    repeat (3) @(negedge clk);
    chk("rst_addr", instruction_address, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    #1 rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;

    goto(1);  chk("start_addr", instruction_address, 1); chk("start_v1", 32'(instr_valid), 0);
    goto(2);  chk("start_pc0", instr_pc, 0); chk("start_i0", instr, 100);
    goto(3);  chk("stream_pc1", instr_pc, 1); chk("stream_i1", instr, 101);
    goto(4);  chk("stream_pc2", instr_pc, 2);
    #1 instr_ready = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      goto(k);
      chk("bp_valid", 32'(instr_valid), 1);
      chk("bp_pc", instr_pc, 2);
      chk("bp_instr", instr, 102);
      chk("bp_addr", instruction_address, 4);
    end
    goto(9);  #1 instr_ready = 1'b1;
    goto(10); chk("rel_pc3", instr_pc, 3);
    goto(11); chk("rel_pc4", instr_pc, 4);
    goto(12); chk("rel_pc5", instr_pc, 5);
    #1 instr_ready = 1'b0;

    goto(14); chk("full_pc", instr_pc, 5); chk("full_addr", instruction_address, 7);
    #1 instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd20;
    goto(15); chk("rd1_addr", instruction_address, 20); chk("rd1_v1", 32'(instr_valid), 0);
    #1 redirect_valid = 1'b0;
    goto(16); chk("rd1_v2", 32'(instr_valid), 0);
    goto(17); chk("rd1_pc", instr_pc, 20); chk("rd1_instr", instr, 120);

    goto(19); chk("pre_rd2_pc", instr_pc, 22);
    #1 redirect_valid = 1'b1; redirect_pc = 32'd8;
    goto(20); chk("rd2_addr", instruction_address, 8); chk("rd2_v1", 32'(instr_valid), 0);
    #1 redirect_valid = 1'b0;
    goto(22); chk("rd2_pc", instr_pc, 8); chk("rd2_instr", instr, 108);

    goto(24); chk("en_pc", instr_pc, 10);
    #1 fetch_en = 1'b0;
    goto(26); chk("idle_valid", 32'(instr_valid), 0); chk("idle_addr", instruction_address, 12);
    goto(27); #1 fetch_en = 1'b1;
    goto(29); chk("resume_pc", instr_pc, 12);

    goto(30); #1 redirect_valid = 1'b1; redirect_pc = 32'd60;
    goto(31); chk("rd3_addr", instruction_address, 60);
    #1 redirect_valid = 1'b0;
    goto(33); chk("rd3_pc", instr_pc, 60);
    goto(35); chk("edge_addr", instruction_address, 64);
`ifdef FETCH_BOUNDS_CHK_EN
    goto(36); chk("flt_set", 32'(fetch_fault), 1); chk("flt_pc63", instr_pc, 63);
    goto(37); chk("flt_drain", 32'(instr_valid), 0); chk("flt_addr", instruction_address, 64);
    #1 redirect_valid = 1'b1; redirect_pc = 32'd0;
    goto(38); chk("flt_rd_ign", instruction_address, 64); chk("flt_sticky", 32'(fetch_fault), 1);
    #1 redirect_valid = 1'b0;
`else
    goto(36); chk("oob_pc63", instr_pc, 63); chk("oob_nofault", 32'(fetch_fault), 0);
    goto(37); chk("oob_pc64", instr_pc, 64); chk("oob_i64", instr, 164);
    #1 redirect_valid = 1'b1; redirect_pc = 32'd0;
    goto(38); chk("oob_rd_addr", instruction_address, 0);
    #1 redirect_valid = 1'b0;
`endif

    goto(42);
    #1 rst_n = 1'b0;
    #1 chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_addr", instruction_address, 0);
    chk("arst_fault", 32'(fetch_fault), 0);
    goto(43); #1 rst_n = 1'b1;
    goto(44); chk("re_addr", instruction_address, 1);
    goto(45); chk("re_pc0", instr_pc, 0); chk("re_i0", instr, 100);
    goto(46); chk("re_pc1", instr_pc, 1);

    goto(48);
    chk("acc_len", 32'(acc.size() >= 19), 1);
    for (int i = 0; i < 19; i++) begin
      if (i < acc.size()) chk("acc_seq", acc[i], 32'(exp_acc[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
